// File: rtl/count_sched_pkg.sv
// Shared types and defaults for the counter scheduler.
package count_sched_pkg;

  localparam int unsigned CwDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/count_sched_if.sv
// Requester and counter-control signals of the counter scheduler.
interface count_sched_if import count_sched_pkg::*; #(
  parameter int unsigned CW = CwDefault
) ();

  logic [1:0]      req;
  logic [2*CW-1:0] start_val;
  logic [2*CW-1:0] end_val;
  logic            abort;
  logic [1:0]      grant;
  logic [1:0]      done;
  logic            busy;
  logic            cnt_enable;
  logic            cnt_load;
  logic [CW-1:0]   cnt_parallel_in;
  logic [CW-1:0]   cnt_value;

  // master: requesters plus the controlled counter; slave: the scheduler
  modport master (
    output req, start_val, end_val, abort, cnt_value,
    input  grant, done, busy, cnt_enable, cnt_load, cnt_parallel_in
  );

  modport slave (
    input  req, start_val, end_val, abort, cnt_value,
    output grant, done, busy, cnt_enable, cnt_load, cnt_parallel_in
  );

endinterface

// File: rtl/count_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  // requester favoured when both request
  logic prio_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
    end else if (update_i && (|req_i)) begin
      prio_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/count_sched.sv
// Schedules two requesters onto one external up-counter: load start, run to end, pulse done.
module count_sched import count_sched_pkg::*; #(
  parameter int unsigned CW = CwDefault
) (
  input  logic         clk,
  input  logic         reset_n,
  count_sched_if.slave bus
);

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [CW-1:0] start_q, start_d;
  logic [CW-1:0] end_q, end_d;
  logic [1:0]    winner;
  logic          arb_update;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (bus.req),
    .update_i (arb_update),
    .gnt_o    (winner)
  );

  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    start_d             = start_q;
    end_d               = end_q;
    arb_update          = 1'b0;
    bus.grant           = 2'b00;
    bus.done            = 2'b00;
    bus.busy            = (state_q != StIdle);
    bus.cnt_enable      = 1'b0;
    bus.cnt_load        = 1'b0;
    bus.cnt_parallel_in = start_q;

    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          arb_update = 1'b1;
          owner_d    = winner;
          start_d    = winner[1] ? bus.start_val[2*CW-1:CW] : bus.start_val[CW-1:0];
          end_d      = winner[1] ? bus.end_val[2*CW-1:CW] : bus.end_val[CW-1:0];
          state_d    = StLoad;
        end
      end
      StLoad: begin
        bus.grant      = owner_q;
        bus.cnt_enable = 1'b1;
        bus.cnt_load   = 1'b1;
        state_d        = bus.abort ? StIdle : StRun;
      end
      StRun: begin
        bus.grant = owner_q;
        if (bus.cnt_value == end_q) begin
          state_d = StDone;
        end else begin
          bus.cnt_enable = 1'b1;
        end
        if (bus.abort) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        bus.done = owner_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= 2'b00;
      start_q <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

endmodule
